// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller, 2**IDX_BITS lines of 4x16-bit words.
// Latency: hit returns data the same cycle. Miss returns data one cycle after the 4th memValid.
// Backpressure: stall holds fetch while the line refills. Only one memRd is outstanding, and it is held until memValid.
//
// Ports:
//   clk, rst           clock (rising edge) and synchronous active-low reset
//   rd, addr, inv      fetch request, byte address, invalidate-all
//   dataOut, done      instruction word and its valid strobe
//   stall, hit, err    hold-fetch, serviced-without-refill, misaligned request
//   memRd, memAddr     backing-memory word read request and address (registered)
//   memData, memValid  backing-memory read data and completion strobe
//   hitCnt, missCnt    saturating event counters, only when ICACHE_PERF_CNT_EN is defined
module icache_ctrl #(
  parameter int IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic        inv,
  output logic [15:0] dataOut,
  output logic        done,
  output logic        stall,
  output logic        hit,
  output logic        err,
  output logic        memRd,
  output logic [15:0] memAddr,
  input  logic [15:0] memData,
  input  logic        memValid
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [15:0] hitCnt,
  output logic [15:0] missCnt
`endif
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = 13 - IDX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t              state_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q   [LINES];
  logic [15:0]         data_q  [LINES][4];
  logic [15:0]         fill_q  [4];
  logic [TAG_W-1:0]    req_tag_q;
  logic [IDX_BITS-1:0] req_idx_q;
  logic [1:0]          req_off_q;
  logic [1:0]          cnt_q;
  logic                inv_pend_q;

  // Address fields of the live fetch request.
  logic [1:0]          a_off;
  logic [IDX_BITS-1:0] a_idx;
  logic [TAG_W-1:0]    a_tag;
  logic                lookup_hit;
  logic                idle_hit;
  logic                idle_miss;

  assign a_off      = addr[2:1];
  assign a_idx      = addr[2+IDX_BITS:3];
  assign a_tag      = addr[15:3+IDX_BITS];
  assign lookup_hit = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign idle_hit   = (state_q == IDLE) && rd && !addr[0] && lookup_hit;
  assign idle_miss  = (state_q == IDLE) && rd && !addr[0] && !lookup_hit;

  // Combinational fetch-side outputs. Everything is forced low while reset is held.
  always_comb begin
    dataOut = '0;
    done    = 1'b0;
    stall   = 1'b0;
    hit     = 1'b0;
    err     = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (rd) begin
            if (addr[0]) begin
              err = 1'b1;
            end else if (lookup_hit) begin
              hit     = 1'b1;
              done    = 1'b1;
              dataOut = data_q[a_idx][a_off];
            end else begin
              stall = 1'b1;
            end
          end
        end
        FILL:  stall = 1'b1;
        WRITE: begin
          done    = 1'b1;
          dataOut = fill_q[req_off_q];
        end
        default: ;
      endcase
    end
  end

  // Refill FSM. The tag and data arrays have no reset: valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      memRd      <= 1'b0;
      memAddr    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The lookup above already used the pre-clear valid bits.
          if (inv) valid_q <= '0;
          if (idle_miss) begin
            req_tag_q <= a_tag;
            req_idx_q <= a_idx;
            req_off_q <= a_off;
            cnt_q     <= '0;
            memRd     <= 1'b1;
            memAddr   <= {a_tag, a_idx, 3'b000};
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (inv) inv_pend_q <= 1'b1;
          if (memRd && memValid) begin
            fill_q[cnt_q] <= memData;
            cnt_q         <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              memRd   <= 1'b0;
              state_q <= WRITE;
            end else begin
              memAddr <= memAddr + 16'd2;
            end
          end
        end
        WRITE: begin
          for (int w = 0; w < 4; w++) data_q[req_idx_q][w] <= fill_q[w];
          tag_q[req_idx_q] <= req_tag_q;
          // An invalidate seen during the refill wins over the freshly written line.
          if (inv_pend_q || inv) valid_q <= '0;
          else                   valid_q[req_idx_q] <= 1'b1;
          inv_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (idle_miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hitCnt  = hit_cnt_q;
  assign missCnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Testbench for icache_ctrl. It uses a fixed-content backing memory (word at A = 16'hA000 + A).
// The reference model keeps only per-index valid and tag, and drives directed, table and random requests.
module tb_icache_ctrl;

  logic        clk, rst, rd, inv, memValid;
  logic [15:0] addr, memData, dataOut, memAddr;
  logic        done, stall, hit, err, memRd;
`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] hitCnt, missCnt;
`endif

  icache_ctrl #(.IDX_BITS(5)) dut (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .inv(inv),
    .dataOut(dataOut), .done(done), .stall(stall), .hit(hit), .err(err),
    .memRd(memRd), .memAddr(memAddr), .memData(memData), .memValid(memValid)
`ifdef ICACHE_PERF_CNT_EN
    , .hitCnt(hitCnt), .missCnt(missCnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 2;
  int acc_cyc = 0;
  int m_hits = 0;
  int m_miss = 0;
  logic [15:0] log_q[$];
  bit          mvalid [32];
  logic [7:0]  mtag   [32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory: answers each memRd after 'lat' idle cycles, one word at a time.
  initial begin
    int wcnt;
    memValid = 1'b0;
    memData  = '0;
    wcnt     = -1;
    forever begin
      @(negedge clk);
      if (memValid) begin
        memValid = 1'b0;
        wcnt     = -1;
      end else if (memRd && rst) begin
        if (wcnt < 0) wcnt = lat;
        if (wcnt == 0) begin
          memValid = 1'b1;
          memData  = 16'hA000 + memAddr;
          log_q.push_back(memAddr);
          acc_cyc  = cyc;
          wcnt     = -1;
        end else begin
          wcnt--;
        end
      end else begin
        wcnt = -1;
      end
    end
  end

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
  endtask

  // One fetch request, checked against the model. inv_now is asserted with the request.
  // inv_mid is pulsed in the first refill cycle.
  task automatic do_req(input logic [15:0] a, input bit inv_now, input bit inv_mid);
    int          idx;
    logic [7:0]  tg;
    logic [15:0] base, exp_d;
    bit          mh;
    int          n;
    idx   = int'(a[7:3]);
    tg    = a[15:8];
    base  = {a[15:3], 3'b000};
    exp_d = 16'hA000 + {a[15:1], 1'b0};
    @(negedge clk);
    rd = 1'b1; addr = a; inv = inv_now;
    #1;
    if (a[0]) begin
      chk1("mis_err", err, 1'b1);
      chk1("mis_done", done, 1'b0);
      chk1("mis_stall", stall, 1'b0);
      chk1("mis_memRd", memRd, 1'b0);
      if (inv_now) mclear();
      return;
    end
    mh = mvalid[idx] && (mtag[idx] == tg);
    chk1("req_hit", hit, mh);
    chk1("req_err", err, 1'b0);
    if (mh) begin
      chk1("hit_done", done, 1'b1);
      chk16("hit_data", dataOut, exp_d);
      chk1("hit_stall", stall, 1'b0);
      chk1("hit_memRd", memRd, 1'b0);
      m_hits++;
      if (inv_now) mclear();
      return;
    end
    chk1("miss_stall", stall, 1'b1);
    chk1("miss_done", done, 1'b0);
    if (inv_now) mclear();
    m_miss++;
    log_q.delete();
    n = 0;
    forever begin
      @(negedge clk);
      inv = (inv_mid && n == 0);
      #1;
      n++;
      if (done) break;
      if (n > 80) begin
        chk1("fill_timeout", done, 1'b1);
        inv = 1'b0;
        return;
      end
      chk1("fill_stall", stall, 1'b1);
      chk1("fill_memRd", memRd, 1'b1);
      chk16("fill_memAddr", memAddr, base + 16'(2 * (log_q.size() - (memValid ? 1 : 0))));
    end
    chk1("wr_hit", hit, 1'b0);
    chk1("wr_stall", stall, 1'b0);
    chk16("wr_data", dataOut, exp_d);
    chk1("wr_memRd", memRd, 1'b0);
    chk16("wr_latency", 16'(cyc), 16'(acc_cyc + 1));
    chk16("wr_nwords", 16'(log_q.size()), 16'd4);
    for (int k = 0; k < 4 && k < log_q.size(); k++)
      chk16("wr_wordaddr", log_q[k], base + 16'(2 * k));
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    if (inv_mid) mclear();
    inv = 1'b0;
  endtask

  typedef struct {
    logic        rst_v;
    logic        rd_v;
    logic [15:0] a;
    logic        done_e;
    logic        stall_e;
    logic        hit_e;
    logic        err_e;
    logic [15:0] data_e;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    logic [15:0] ra;
    // Input vectors for the single-cycle table. The table runs after the line at 0x0020 has been filled.
    tbl[0] = '{1'b1, 1'b0, 16'h0024, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 16'h0026, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA026};
    tbl[2] = '{1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA020};
    tbl[3] = '{1'b1, 1'b1, 16'h0022, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA022};
    tbl[4] = '{1'b1, 1'b1, 16'h0031, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 16'h0025, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 16'h0026, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    // Hold reset with an active request: outputs must be forced low.
    rst = 1'b0; rd = 1'b1; addr = 16'h0024; inv = 1'b0;
    mclear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk1("rst_done", done, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_hit", hit, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk16("rst_data", dataOut, 16'h0000);
    chk1("rst_memRd", memRd, 1'b0);
    chk16("rst_memAddr", memAddr, 16'h0000);
    rst = 1'b1; rd = 1'b0;

    // Cold miss on 0x0024 with memory latency 2.
    lat = 2;
    do_req(16'h0024, 1'b0, 1'b0);

    // Table: hits, misaligned requests and forced outputs during reset.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = tbl[i].rst_v; rd = tbl[i].rd_v; addr = tbl[i].a; inv = 1'b0;
      #1;
      chk1("tbl_done", done, tbl[i].done_e);
      chk1("tbl_stall", stall, tbl[i].stall_e);
      chk1("tbl_hit", hit, tbl[i].hit_e);
      chk1("tbl_err", err, tbl[i].err_e);
      chk1("tbl_memRd", memRd, 1'b0);
      if (tbl[i].done_e || !tbl[i].rd_v || !tbl[i].rst_v)
        chk16("tbl_data", dataOut, tbl[i].data_e);
      if (tbl[i].hit_e && tbl[i].rst_v) m_hits++;
    end
    @(negedge clk);
    rst = 1'b1; rd = 1'b0;
    mclear();
    m_hits = 0; m_miss = 0;

    // Conflict misses: 0x0024 and 0x0124 share an index.
    do_req(16'h0024, 1'b0, 1'b0);
    do_req(16'h0124, 1'b0, 1'b0);
    do_req(16'h0026, 1'b0, 1'b0);
    do_req(16'h0024, 1'b0, 1'b0);
    do_req(16'h0124, 1'b0, 1'b0);

    // Reset after the second accepted word of a refill.
    lat = 1;
    @(negedge clk);
    rd = 1'b1; addr = 16'h0044; inv = 1'b0;
    log_q.delete();
    #1;
    chk1("rmf_stall", stall, 1'b1);
    n = 0;
    while (!(log_q.size() == 2 && !memValid) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk16("rmf_words_before_reset", 16'(log_q.size()), 16'd2);
    rst = 1'b0; rd = 1'b0;
    @(posedge clk);
    #1;
    chk1("rmf_memRd", memRd, 1'b0);
    chk1("rmf_stall_after", stall, 1'b0);
    chk1("rmf_done_after", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    mclear();
    m_hits = 0; m_miss = 0;
    do_req(16'h0044, 1'b0, 1'b0);
    do_req(16'h0040, 1'b0, 1'b0);

    // Invalidate during a refill: data still returned, the line is gone afterwards.
    lat = 2;
    do_req(16'h0064, 1'b0, 1'b1);
    do_req(16'h0062, 1'b0, 1'b0);
    do_req(16'h0066, 1'b0, 1'b0);
    // Invalidate in IDLE together with a hit: the lookup uses the old state.
    do_req(16'h0060, 1'b1, 1'b0);
    do_req(16'h0060, 1'b0, 1'b0);

    // Random requests over a small address pool so that hits and conflicts both occur.
    for (int t = 0; t < 300; t++) begin
      lat = $urandom_range(0, 3);
      ra  = {6'b0, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0)};
      do_req(ra, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
    end

    @(negedge clk);
    rd = 1'b0; inv = 1'b0;
    #1;
    chk1("end_done", done, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
    chk16("hitCnt", hitCnt, 16'(m_hits));
    chk16("missCnt", missCnt, 16'(m_miss));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
